// File: rtl/onehot_encoder_reg.sv
// Registered lowest-set-bit encoder with valid/ready handshake and conversion counter.
// Define ONEHOT_CHECK_EN to flag accepted words that have more than one bit set on out_err.
module onehot_encoder_reg #(
  parameter int N     = 8,
  parameter int CNT_W = 16,
  localparam int W    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     out_code,
  output logic             out_none,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] conv_cnt
);

  // state | meaning
  // EMPTY | no result held, out_valid=0
  // FULL  | result held until out_ready, out_valid=1
  typedef enum logic {EMPTY, FULL} state_t;

  state_t         state;
  logic           accept;
  logic [W-1:0]   low_code;

  assign in_ready = (state == EMPTY) || out_ready;
  assign accept   = in_valid && in_ready;

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    low_code = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_data[i]) low_code = W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_none  <= 1'b0;
      conv_cnt  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            state     <= FULL;
            out_valid <= 1'b1;
          end
        end
        FULL: begin
          if (out_ready && !in_valid) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
      if (accept) begin
        out_code <= low_code;
        out_none <= ~|in_data;
        conv_cnt <= conv_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

`ifdef ONEHOT_CHECK_EN
  logic multi_hot;

  // Clearing the lowest set bit leaves something only if a second bit was set.
  assign multi_hot = |(in_data & (in_data - {{(N-1){1'b0}}, 1'b1}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_err <= 1'b0;
    end else if (accept) begin
      out_err <= multi_hot;
    end
  end
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_encoder_reg.sv
// Bench for onehot_encoder_reg: N=8/CNT_W=4 directed instance and N=16 random instance,
// each checked every cycle against a queue model of accepted words.
module tb_onehot_encoder_reg;

  logic        clk;
  logic        rst;

  logic [7:0]  a_in_data;
  logic        a_in_valid, a_in_ready;
  logic [2:0]  a_out_code;
  logic        a_out_none, a_out_err, a_out_valid, a_out_ready;
  logic [3:0]  a_conv_cnt;

  logic [15:0] b_in_data;
  logic        b_in_valid, b_in_ready;
  logic [3:0]  b_out_code;
  logic        b_out_none, b_out_err, b_out_valid, b_out_ready;
  logic [15:0] b_conv_cnt;

  int checks = 0;
  int errors = 0;

  onehot_encoder_reg #(.N(8), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_code(a_out_code), .out_none(a_out_none), .out_err(a_out_err),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .conv_cnt(a_conv_cnt)
  );

  onehot_encoder_reg #(.N(16), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_code(b_out_code), .out_none(b_out_none), .out_err(b_out_err),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .conv_cnt(b_conv_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_idx(input logic [15:0] w);
    logic [15:0] iso;
    iso = w & (~w + 16'd1);
    return $clog2(iso);
  endfunction

  function automatic int exp_err(input logic [15:0] w);
`ifdef ONEHOT_CHECK_EN
    return ($countones(w) > 1) ? 1 : 0;
`else
    return (w == 16'd0) ? 0 : 0;
`endif
  endfunction

  // Reference models: queue of accepted words awaiting consumption.
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  int cnt_a = 0, cnt_b = 0, done_b = 0;

  always @(negedge clk) begin
    bit rdy;
    if (rst) begin
      qa.delete();
      cnt_a = 0;
      chk("a_rst_valid", int'(a_out_valid), 0);
      chk("a_rst_code", int'(a_out_code), 0);
      chk("a_rst_cnt", int'(a_conv_cnt), 0);
    end else begin
      rdy = (qa.size() == 0) || a_out_ready;
      chk("a_in_ready", int'(a_in_ready), int'(rdy));
      chk("a_out_valid", int'(a_out_valid), (qa.size() > 0) ? 1 : 0);
      chk("a_conv_cnt", int'(a_conv_cnt), cnt_a % 16);
      if (qa.size() > 0) begin
        chk("a_out_code", int'(a_out_code), lowest_idx(qa[0]));
        chk("a_out_none", int'(a_out_none), (qa[0] == 16'd0) ? 1 : 0);
        chk("a_out_err", int'(a_out_err), exp_err(qa[0]));
        if (a_out_ready) void'(qa.pop_front());
      end
      if (a_in_valid && rdy) begin
        qa.push_back({8'h00, a_in_data});
        cnt_a++;
      end
    end
  end

  always @(negedge clk) begin
    bit rdy;
    if (rst) begin
      qb.delete();
      cnt_b = 0;
      chk("b_rst_valid", int'(b_out_valid), 0);
      chk("b_rst_cnt", int'(b_conv_cnt), 0);
    end else begin
      rdy = (qb.size() == 0) || b_out_ready;
      chk("b_in_ready", int'(b_in_ready), int'(rdy));
      chk("b_out_valid", int'(b_out_valid), (qb.size() > 0) ? 1 : 0);
      chk("b_conv_cnt", int'(b_conv_cnt), cnt_b % 65536);
      if (qb.size() > 0) begin
        chk("b_out_code", int'(b_out_code), lowest_idx(qb[0]));
        chk("b_out_none", int'(b_out_none), (qb[0] == 16'd0) ? 1 : 0);
        chk("b_out_err", int'(b_out_err), exp_err(qb[0]));
        if (b_out_ready) begin
          void'(qb.pop_front());
          done_b++;
        end
      end
      if (b_in_valid && rdy) begin
        qb.push_back(b_in_data);
        cnt_b++;
      end
    end
  end

  task automatic cyc_a(input logic v, input logic [7:0] d, input logic r);
    a_in_valid  = v;
    a_in_data   = d;
    a_out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  oh;
    logic [15:0] rd;
    int exp_e;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = 16'h0000; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rel_in_ready", int'(a_in_ready), 1);

    // Walking one-hot at full throughput.
    for (int i = 0; i < 8; i++) begin
      oh = 8'h01 << i;
      cyc_a(1'b1, oh, 1'b1);
      chk("walk_code", int'(a_out_code), i);
      chk("walk_none", int'(a_out_none), 0);
      chk("walk_ready", int'(a_in_ready), 1);
    end
    chk("walk_cnt", int'(a_conv_cnt), 8);

    cyc_a(1'b1, 8'h00, 1'b1);
    chk("zero_none", int'(a_out_none), 1);
    chk("zero_code", int'(a_out_code), 0);
    cyc_a(1'b1, 8'h28, 1'b1);
    chk("multi_code", int'(a_out_code), 3);
`ifdef ONEHOT_CHECK_EN
    exp_e = 1;
`else
    exp_e = 0;
`endif
    chk("multi_err", int'(a_out_err), exp_e);
    chk("multi_cnt", int'(a_conv_cnt), 10);

    // Backpressure with a pending word waiting on the input.
    cyc_a(1'b1, 8'h10, 1'b1);
    chk("bp_code0", int'(a_out_code), 4);
    for (int i = 0; i < 5; i++) begin
      cyc_a(1'b1, 8'h02, 1'b0);
      chk("bp_hold_code", int'(a_out_code), 4);
      chk("bp_in_ready", int'(a_in_ready), 0);
      chk("bp_cnt", int'(a_conv_cnt), 11);
    end
    cyc_a(1'b1, 8'h02, 1'b1);
    chk("bp_new_code", int'(a_out_code), 1);
    chk("bp_new_cnt", int'(a_conv_cnt), 12);
    cyc_a(1'b0, 8'h00, 1'b1);
    chk("drain_valid", int'(a_out_valid), 0);

    // Reset while a word is held.
    cyc_a(1'b1, 8'h04, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_now_valid", int'(a_out_valid), 0);
    chk("rst_now_code", int'(a_out_code), 0);
    chk("rst_now_cnt", int'(a_conv_cnt), 0);
    cyc_a(1'b1, 8'h08, 1'b1);
    cyc_a(1'b0, 8'h00, 1'b1);
    rst = 1'b0;
    #1;
    chk("rst_rel_ready", int'(a_in_ready), 1);
    chk("rst_rel_valid", int'(a_out_valid), 0);

    // Counter wrap with a 4-bit counter.
    for (int i = 1; i <= 17; i++) begin
      oh = 8'(i);
      cyc_a(1'b1, oh, 1'b1);
      if (i == 15) chk("wrap_15", int'(a_conv_cnt), 15);
      if (i == 16) chk("wrap_0", int'(a_conv_cnt), 0);
      if (i == 17) chk("wrap_1", int'(a_conv_cnt), 1);
    end
    cyc_a(1'b0, 8'h00, 1'b1);

    // Random valid/ready on the 16-bit instance.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: rd = 16'h0000;
        1: rd = 16'h0001 << $urandom_range(0, 15);
        default: rd = 16'($urandom);
      endcase
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_in_data   = rd;
      b_out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("b_drained", qb.size(), 0);
    chk("b_no_loss", done_b, cnt_b);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
